// File: rtl/ext_clock_monitor.sv
// Qualifies the external 10 MHz reference: counts synchronized ext rising edges per
// gate window and runs a LOST/QUALIFY/VALID FSM with tolerance and fast-loss checks.
module ext_clock_monitor #(
  parameter int COUNT_WIDTH    = 16,
  parameter int GATE_CYCLES    = 2500,
  parameter int EXPECTED_COUNT = 100,
  parameter int TOLERANCE      = 2,
  parameter int GOOD_WINDOWS   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_10mhz_ext,
  output logic                   ext_clock_valid,
  output logic                   ext_clock_lost,
  output logic                   window_done,
  output logic [COUNT_WIDTH-1:0] edge_count
);

  localparam int WIN_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GOOD_W = $clog2(GOOD_WINDOWS + 1);

  localparam logic [WIN_W-1:0]       WIN_LAST    = WIN_W'(GATE_CYCLES - 1);
  localparam logic [TO_W-1:0]        TO_LIMIT    = TO_W'(TIMEOUT_CYCLES);
  localparam logic [GOOD_W-1:0]      GOOD_TARGET = GOOD_W'(GOOD_WINDOWS);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [COUNT_WIDTH-1:0] EXP_C       = COUNT_WIDTH'(EXPECTED_COUNT);
  localparam logic [COUNT_WIDTH-1:0] TOL_C       = COUNT_WIDTH'(TOLERANCE);

  typedef enum logic [1:0] {ST_LOST, ST_QUALIFY, ST_VALID} state_e;

  logic                   sync1_q, sync2_q, prev_q;
  logic [WIN_W-1:0]       win_q, win_d;
  logic [COUNT_WIDTH-1:0] run_q, run_d, edge_count_q, close_cnt, dev;
  logic [TO_W-1:0]        to_q, to_d;
  logic [GOOD_W-1:0]      good_q, good_d;
  state_e                 state_q, state_d;
  logic                   valid_q, lost_q, done_q, lost_d;
  logic                   edge_det, win_last, win_good, timeout;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    edge_det  = sync2_q & ~prev_q;
    win_last  = (win_q == WIN_LAST);
    timeout   = (to_q == TO_LIMIT);
    close_cnt = (edge_det && run_q != CNT_MAX) ? run_q + 1'b1 : run_q;
    dev       = (close_cnt >= EXP_C) ? close_cnt - EXP_C : EXP_C - close_cnt;
    win_good  = (dev <= TOL_C);
    win_d     = win_last ? '0 : win_q + 1'b1;
    run_d     = win_last ? '0 : close_cnt;
    if (edge_det)       to_d = '0;
    else if (!timeout)  to_d = to_q + 1'b1;
    else                to_d = to_q;
  end

  // Timeout is checked before the window score, so a coincident close is not scored.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    unique case (state_q)
      ST_LOST: begin
        if (edge_det) begin
          state_d = ST_QUALIFY;
          good_d  = '0;
        end
      end
      ST_QUALIFY: begin
        if (timeout) begin
          state_d = ST_LOST;
        end else if (win_last) begin
          if (win_good) begin
            good_d = good_q + 1'b1;
            if (good_q + 1'b1 == GOOD_TARGET) state_d = ST_VALID;
          end else begin
            good_d = '0;
          end
        end
      end
      ST_VALID: begin
        if (timeout || (win_last && !win_good)) state_d = ST_LOST;
      end
      default: state_d = ST_LOST;
    endcase
    lost_d = (state_q != ST_LOST) && (state_d == ST_LOST);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      win_q        <= '0;
      run_q        <= '0;
      to_q         <= '0;
      good_q       <= '0;
      state_q      <= ST_LOST;
      valid_q      <= 1'b0;
      lost_q       <= 1'b0;
      done_q       <= 1'b0;
      edge_count_q <= '0;
    end else begin
      // clk_10mhz_ext is asynchronous: two flops before any logic looks at it.
      sync1_q <= clk_10mhz_ext;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      win_q   <= win_d;
      run_q   <= run_d;
      to_q    <= to_d;
      good_q  <= good_d;
      state_q <= state_d;
      valid_q <= (state_d == ST_VALID);
      lost_q  <= lost_d;
      done_q  <= win_last;
      if (win_last) edge_count_q <= close_cnt;
    end
  end

  assign ext_clock_valid = valid_q;
  assign ext_clock_lost  = lost_q;
  assign window_done     = done_q;
  assign edge_count      = edge_count_q;

endmodule

// File: tb/tb_ext_clock_monitor.sv
// Self-checking bench for ext_clock_monitor: per-window expectations are queued when the
// ext stimulus is set up and popped at each window_done.
module tb_ext_clock_monitor;

  localparam int CW      = 16;
  localparam int GATE    = 1000;
  localparam int EXPC    = 40;
  localparam int TOL     = 2;
  localparam int GOODW   = 4;
  localparam int TIMEOUT = 64;
  localparam int CLK_P   = 4;

  typedef struct {
    bit chk_cnt;
    int lo;
    int hi;
    bit valid;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_10mhz_ext;
  logic          ext_clock_valid, ext_clock_lost, window_done;
  logic [CW-1:0] edge_count;

  int   ext_period = 25;
  bit   ext_run = 1'b0, stop_req = 1'b0, stop_lvl = 1'b0;
  time  last_rise_t = 0, valid_fall_t = 0;
  int   lost_cnt = 0;
  int   checks = 0, errors = 0;
  exp_t exp_q[$];

  ext_clock_monitor #(
    .COUNT_WIDTH(CW), .GATE_CYCLES(GATE), .EXPECTED_COUNT(EXPC),
    .TOLERANCE(TOL), .GOOD_WINDOWS(GOODW), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_10mhz_ext(clk_10mhz_ext),
    .ext_clock_valid(ext_clock_valid), .ext_clock_lost(ext_clock_lost),
    .window_done(window_done), .edge_count(edge_count)
  );

  initial forever #(CLK_P/2) clk = ~clk;

  // Ext generator toggles on odd time units, clk edges fall on even ones.
  initial begin
    clk_10mhz_ext = 1'b0;
    #1;
    forever begin
      if (ext_run) begin
        #(ext_period * CLK_P / 2);
        clk_10mhz_ext = ~clk_10mhz_ext;
        if (clk_10mhz_ext) last_rise_t = $time;
        if (stop_req && clk_10mhz_ext == stop_lvl) begin
          ext_run  = 1'b0;
          stop_req = 1'b0;
        end
      end else begin
        #2;
      end
    end
  end

  always @(negedge clk) if (ext_clock_lost === 1'b1) lost_cnt++;
  always @(negedge ext_clock_valid) valid_fall_t = $time;

  initial begin
    #(100000 * CLK_P);
    $display("FAIL watchdog: simulation exceeded 100000 clk");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(bit c, int lo, int hi, bit v);
    exp_t e;
    e.chk_cnt = c; e.lo = lo; e.hi = hi; e.valid = v;
    return e;
  endfunction

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < GATE + 50; i++) begin
      @(negedge clk);
      if (window_done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_stopped(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!ext_run) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ext_clock_valid === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    bit   ok;
    ext_run = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (ext_clock_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ext_clock_valid); end
    if (ext_clock_lost  !== 1'b0) begin errors++; $display("FAIL rst_lost: got %b want 0", ext_clock_lost); end
    if (window_done     !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", window_done); end
    if (edge_count      !== '0)   begin errors++; $display("FAIL rst_count: got %0d want 0", edge_count); end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) exp_q.push_back(mk(1'b1, 0, 0, 1'b0));
    for (int i = 0; i < 10; i++) begin
      wait_done(ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin errors++; $display("FAIL idle_done[%0d]: no window_done within %0d clk", i, GATE + 50); end
      else begin
        checks += 2;
        if (int'(edge_count) < e.lo || int'(edge_count) > e.hi) begin
          errors++; $display("FAIL idle_count[%0d]: got %0d want %0d..%0d", i, edge_count, e.lo, e.hi);
        end
        if (ext_clock_valid !== e.valid) begin
          errors++; $display("FAIL idle_valid[%0d]: got %b want %b", i, ext_clock_valid, e.valid);
        end
      end
    end
    checks++;
    if (lost_cnt !== 0) begin errors++; $display("FAIL idle_lost: got %0d pulses want 0", lost_cnt); end
  endtask

  task automatic test_qualify();
    exp_t e;
    bit   ok;
    int   l0;
    l0 = lost_cnt;
    repeat (300) @(negedge clk);
    ext_period = 25;
    ext_run    = 1'b1;
    exp_q.push_back(mk(1'b0, 0, 0, 1'b0));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b1, EXPC - 1, EXPC + 1, 1'b0));
    exp_q.push_back(mk(1'b1, EXPC - 1, EXPC + 1, 1'b1));
    for (int i = 0; i < 5; i++) begin
      wait_done(ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin errors++; $display("FAIL qual_done[%0d]: no window_done within %0d clk", i, GATE + 50); end
      else begin
        checks++;
        if (ext_clock_valid !== e.valid) begin
          errors++; $display("FAIL qual_valid[%0d]: got %b want %b", i, ext_clock_valid, e.valid);
        end
        if (e.chk_cnt) begin
          checks++;
          if (int'(edge_count) < e.lo || int'(edge_count) > e.hi) begin
            errors++; $display("FAIL qual_count[%0d]: got %0d want %0d..%0d", i, edge_count, e.lo, e.hi);
          end
        end
      end
    end
    checks++;
    if (lost_cnt !== l0) begin errors++; $display("FAIL qual_lost: got %0d pulses want 0", lost_cnt - l0); end
  endtask

  task automatic test_loss();
    bit  ok;
    int  l0;
    time t0;
    l0 = lost_cnt;
    stop_lvl = 1'b1;
    stop_req = 1'b1;
    wait_stopped(ok);
    t0 = last_rise_t;
    checks++;
    if (!ok) begin errors++; $display("FAIL loss_stop: ext generator still running after 200 clk"); end
    wait_valid_low(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL loss_valid: valid still %b 200 clk after stop want 0", ext_clock_valid); end
    else begin
      checks++;
      if (valid_fall_t <= t0 || valid_fall_t - t0 > time'((TIMEOUT + 4) * CLK_P)) begin
        errors++; $display("FAIL loss_latency: valid fell %0t after last edge want <= %0d", valid_fall_t - t0, (TIMEOUT + 4) * CLK_P);
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (lost_cnt !== l0 + 1) begin errors++; $display("FAIL loss_pulse: got %0d pulses want 1", lost_cnt - l0); end
  endtask

  task automatic test_bad_freq();
    exp_t e;
    bit   ok;
    int   l0;
    l0 = lost_cnt;
    ext_period = 28;
    ext_run    = 1'b1;
    exp_q.push_back(mk(1'b0, 0, 0, 1'b0));
    for (int i = 0; i < 19; i++) exp_q.push_back(mk(1'b1, 35, 36, 1'b0));
    for (int i = 0; i < 20; i++) begin
      wait_done(ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin errors++; $display("FAIL slow_done[%0d]: no window_done within %0d clk", i, GATE + 50); end
      else begin
        checks += 2;
        if (ext_clock_valid !== e.valid) begin
          errors++; $display("FAIL slow_valid[%0d]: got %b want %b", i, ext_clock_valid, e.valid);
        end
        if (dut.good_q !== '0) begin
          errors++; $display("FAIL slow_good[%0d]: good counter %0d want 0", i, dut.good_q);
        end
        if (e.chk_cnt) begin
          checks++;
          if (int'(edge_count) < e.lo || int'(edge_count) > e.hi) begin
            errors++; $display("FAIL slow_count[%0d]: got %0d want %0d..%0d", i, edge_count, e.lo, e.hi);
          end
        end
      end
    end
    checks++;
    if (lost_cnt !== l0) begin errors++; $display("FAIL slow_lost: got %0d pulses want 0", lost_cnt - l0); end
  endtask

  task automatic test_freq_glitch();
    exp_t e;
    bit   ok, got_valid;
    int   l0;
    ext_period = 25;
    got_valid  = 1'b0;
    for (int i = 0; i < 8 && !got_valid; i++) begin
      wait_done(ok);
      if (ok && ext_clock_valid === 1'b1) got_valid = 1'b1;
    end
    checks++;
    if (!got_valid) begin errors++; $display("FAIL glitch_pre: valid %b after 8 windows want 1", ext_clock_valid); end
    l0 = lost_cnt;
    ext_period = 22;
    exp_q.push_back(mk(1'b1, EXPC + TOL + 1, 1000, 1'b0));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b1, EXPC - 1, EXPC + 1, 1'b0));
    exp_q.push_back(mk(1'b1, EXPC - 1, EXPC + 1, 1'b1));
    for (int i = 0; i < 5; i++) begin
      wait_done(ok);
      if (i == 0) ext_period = 25;
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin errors++; $display("FAIL glitch_done[%0d]: no window_done within %0d clk", i, GATE + 50); end
      else begin
        checks += 2;
        if (ext_clock_valid !== e.valid) begin
          errors++; $display("FAIL glitch_valid[%0d]: got %b want %b", i, ext_clock_valid, e.valid);
        end
        if (int'(edge_count) < e.lo || int'(edge_count) > e.hi) begin
          errors++; $display("FAIL glitch_count[%0d]: got %0d want %0d..%0d", i, edge_count, e.lo, e.hi);
        end
      end
    end
    checks++;
    if (lost_cnt !== l0 + 1) begin errors++; $display("FAIL glitch_lost: got %0d pulses want 1", lost_cnt - l0); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   ok;
    stop_lvl = 1'b1;
    stop_req = 1'b1;
    wait_stopped(ok);
    wait_valid_low(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rmid_drop: valid %b after stop want 0", ext_clock_valid); end
    repeat (200) @(negedge clk);
    ext_run = 1'b1;
    exp_q.push_back(mk(1'b0, 0, 0, 1'b0));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b1, EXPC - 1, EXPC + 1, 1'b0));
    for (int i = 0; i < 4; i++) begin
      wait_done(ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin errors++; $display("FAIL rmid_pre_done[%0d]: no window_done within %0d clk", i, GATE + 50); end
      else begin
        checks++;
        if (ext_clock_valid !== e.valid) begin
          errors++; $display("FAIL rmid_pre_valid[%0d]: got %b want %b", i, ext_clock_valid, e.valid);
        end
        if (e.chk_cnt) begin
          checks++;
          if (int'(edge_count) < e.lo || int'(edge_count) > e.hi) begin
            errors++; $display("FAIL rmid_pre_count[%0d]: got %0d want %0d..%0d", i, edge_count, e.lo, e.hi);
          end
        end
      end
    end
    checks++;
    if (dut.good_q !== 3) begin errors++; $display("FAIL rmid_good: good counter %0d want 3", dut.good_q); end
    repeat (200) @(negedge clk);
    stop_lvl = 1'b0;
    stop_req = 1'b1;
    wait_stopped(ok);
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (ext_clock_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", ext_clock_valid); end
    if (ext_clock_lost  !== 1'b0) begin errors++; $display("FAIL rmid_lost: got %b want 0", ext_clock_lost); end
    if (window_done     !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b want 0", window_done); end
    if (edge_count      !== '0)   begin errors++; $display("FAIL rmid_count: got %0d want 0", edge_count); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    ext_run = 1'b1;
    exp_q.push_back(mk(1'b0, 0, 0, 1'b0));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b1, EXPC - 1, EXPC + 1, 1'b0));
    exp_q.push_back(mk(1'b1, EXPC - 1, EXPC + 1, 1'b1));
    for (int i = 0; i < 5; i++) begin
      wait_done(ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin errors++; $display("FAIL rmid_post_done[%0d]: no window_done within %0d clk", i, GATE + 50); end
      else begin
        checks++;
        if (ext_clock_valid !== e.valid) begin
          errors++; $display("FAIL rmid_post_valid[%0d]: got %b want %b", i, ext_clock_valid, e.valid);
        end
        if (e.chk_cnt) begin
          checks++;
          if (int'(edge_count) < e.lo || int'(edge_count) > e.hi) begin
            errors++; $display("FAIL rmid_post_count[%0d]: got %0d want %0d..%0d", i, edge_count, e.lo, e.hi);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_qualify();
    test_loss();
    test_bad_freq();
    test_freq_glitch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
